// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Owns the PC, talks to
// instruction memory over req/ready, and honours decode stall and redirect flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic [31:0] PCPlus4,
  output logic        InstrValid
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] pending_pc_r;
  logic [31:0] skid_r;
  logic        req_r;

  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;
  logic        hit_s;
  logic        unused_s;

  assign target_s   = {RedirectPC[31:2], 2'b00};
  assign pc_plus4_s = pc_r + 32'd4;
  // Ready only counts while a request is actually on the bus.
  assign hit_s      = req_r & IMemReady;
  assign unused_s   = ^RedirectPC[1:0];

  assign IMemReq  = req_r;
  assign IMemAddr = pc_r;

  // Fetch FSM, PC, skid buffer and IF/ID register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r      <= FETCH;
      pc_r         <= {RESET_PC[31:2], 2'b00};
      pending_pc_r <= 32'd0;
      skid_r       <= 32'd0;
      req_r        <= 1'b0;
      Instruction  <= 32'd0;
      InstrPC      <= 32'd0;
      PCPlus4      <= 32'd0;
      InstrValid   <= 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          req_r <= 1'b1;
          if (Redirect) begin
            Instruction <= 32'd0;
            InstrPC     <= 32'd0;
            PCPlus4     <= 32'd0;
            InstrValid  <= 1'b0;
            if (req_r && !IMemReady) begin
              // Request already on the bus must complete before refetching.
              pending_pc_r <= target_s;
              state_r      <= DISCARD;
            end else begin
              pc_r    <= target_s;
              state_r <= FETCH;
            end
          end else if (hit_s) begin
            if (Stall) begin
              skid_r  <= IMemData;
              req_r   <= 1'b0;
              state_r <= HOLD;
            end else begin
              Instruction <= IMemData;
              InstrPC     <= pc_r;
              PCPlus4     <= pc_plus4_s;
              InstrValid  <= 1'b1;
              pc_r        <= pc_plus4_s;
              state_r     <= FETCH;
            end
          end else if (!Stall) begin
            Instruction <= 32'd0;
            InstrPC     <= 32'd0;
            PCPlus4     <= 32'd0;
            InstrValid  <= 1'b0;
            state_r     <= FETCH;
          end else begin
            state_r <= FETCH;
          end
        end

        HOLD: begin
          if (Redirect) begin
            Instruction <= 32'd0;
            InstrPC     <= 32'd0;
            PCPlus4     <= 32'd0;
            InstrValid  <= 1'b0;
            skid_r      <= 32'd0;
            pc_r        <= target_s;
            req_r       <= 1'b1;
            state_r     <= FETCH;
          end else if (Stall) begin
            req_r   <= 1'b0;
            state_r <= HOLD;
          end else begin
            Instruction <= skid_r;
            InstrPC     <= pc_r;
            PCPlus4     <= pc_plus4_s;
            InstrValid  <= 1'b1;
            pc_r        <= pc_plus4_s;
            req_r       <= 1'b1;
            state_r     <= FETCH;
          end
        end

        DISCARD: begin
          req_r       <= 1'b1;
          Instruction <= 32'd0;
          InstrPC     <= 32'd0;
          PCPlus4     <= 32'd0;
          InstrValid  <= 1'b0;
          if (Redirect) begin
            pending_pc_r <= target_s;
          end else begin
            pending_pc_r <= pending_pc_r;
          end
          if (IMemReady) begin
            pc_r    <= Redirect ? target_s : pending_pc_r;
            state_r <= FETCH;
          end else begin
            state_r <= DISCARD;
          end
        end

        default: begin
          req_r       <= 1'b1;
          Instruction <= 32'd0;
          InstrPC     <= 32'd0;
          PCPlus4     <= 32'd0;
          InstrValid  <= 1'b0;
          state_r     <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns address-tagged words
// (data = addr + 32'h1000_0000) so every expected value is hand-derivable.
module tb_fetch_stage;

  logic        Clock;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
  logic [31:0] PCPlus4;
  logic        InstrValid;

  int vectors_applied;
  int miscompares;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemReady  (IMemReady),
    .IMemData   (IMemData),
    .Instruction(Instruction),
    .InstrPC    (InstrPC),
    .PCPlus4    (PCPlus4),
    .InstrValid (InstrValid)
  );

  assign IMemData = IMemAddr + 32'h1000_0000;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge, then confirm a bubble always carries a NoOp.
  task automatic tick();
    @(posedge Clock);
    #1;
    if (InstrValid === 1'b0) check_value("nop_when_invalid", Instruction, 32'h0000_0000);
  endtask

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    Reset      = 1'b1;
    Stall      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 32'h0000_0000;
    IMemReady  = 1'b0;
    tick();
    tick();
    check_value("rst_req",   {31'd0, IMemReq},    32'd0);
    check_value("rst_valid", {31'd0, InstrValid}, 32'd0);
    check_value("rst_pc4",   PCPlus4,             32'd0);

    // Streaming with zero-wait memory
    Reset = 1'b0; IMemReady = 1'b1;
    tick();
    check_value("first_req",  {31'd0, IMemReq}, 32'd1);
    check_value("first_addr", IMemAddr,         32'h0000_0000);
    tick();
    check_value("addr_4",  IMemAddr,    32'h0000_0004);
    check_value("ins_0",   Instruction, 32'h1000_0000);
    check_value("ipc_0",   InstrPC,     32'h0000_0000);
    check_value("pc4_0",   PCPlus4,     32'h0000_0004);
    tick();
    check_value("addr_8",  IMemAddr,    32'h0000_0008);
    check_value("ipc_4",   InstrPC,     32'h0000_0004);

    // Stall three cycles with word@8 ready -> skid, HOLD
    Stall = 1'b1;
    tick();
    check_value("hold_req",  {31'd0, IMemReq}, 32'd0);
    check_value("hold_ins",  Instruction,      32'h1000_0004);
    tick();
    tick();
    check_value("hold3_req", {31'd0, IMemReq}, 32'd0);
    check_value("hold3_ipc", InstrPC,          32'h0000_0004);
    Stall = 1'b0;
    tick();
    check_value("skid_ins",  Instruction, 32'h1000_0008);
    check_value("skid_ipc",  InstrPC,     32'h0000_0008);
    check_value("skid_addr", IMemAddr,    32'h0000_000C);
    tick();
    check_value("ipc_c",     InstrPC,     32'h0000_000C);
    check_value("addr_10",   IMemAddr,    32'h0000_0010);

    // Two wait states at 0x10
    IMemReady = 1'b0;
    tick();
    check_value("wait1_addr",  IMemAddr,            32'h0000_0010);
    check_value("wait1_valid", {31'd0, InstrValid}, 32'd0);
    tick();
    check_value("wait2_addr",  IMemAddr,            32'h0000_0010);
    check_value("wait2_req",   {31'd0, IMemReq},    32'd1);
    IMemReady = 1'b1;
    tick();
    check_value("wait_ins",  Instruction, 32'h1000_0010);
    check_value("wait_addr", IMemAddr,    32'h0000_0014);

    // Redirect to 0x40 while 0x14 is outstanding
    IMemReady = 1'b0; Redirect = 1'b1; RedirectPC = 32'h0000_0040;
    tick();
    check_value("disc_addr",  IMemAddr,            32'h0000_0014);
    check_value("disc_valid", {31'd0, InstrValid}, 32'd0);
    Redirect = 1'b0;
    tick();
    check_value("disc2_addr", IMemAddr, 32'h0000_0014);
    IMemReady = 1'b1;
    tick();
    check_value("redir_addr",  IMemAddr,            32'h0000_0040);
    check_value("redir_valid", {31'd0, InstrValid}, 32'd0);
    tick();
    check_value("redir_ins", Instruction, 32'h1000_0040);
    check_value("redir_ipc", InstrPC,     32'h0000_0040);

    // Enter HOLD at 0x44, then Redirect+Stall to 0x103
    Stall = 1'b1;
    tick();
    check_value("hold44_req", {31'd0, IMemReq}, 32'd0);
    Redirect = 1'b1; RedirectPC = 32'h0000_0103;
    tick();
    check_value("hflush_ins",  Instruction,         32'h0000_0000);
    check_value("hflush_val",  {31'd0, InstrValid}, 32'd0);
    check_value("hflush_addr", IMemAddr,            32'h0000_0100);
    check_value("hflush_req",  {31'd0, IMemReq},    32'd1);
    Redirect = 1'b0; Stall = 1'b0;
    tick();
    check_value("ins_100", Instruction, 32'h1000_0100);

    // Wrap at the top of the address space
    Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
    tick();
    check_value("wrap_addr",  IMemAddr,            32'hFFFF_FFFC);
    check_value("wrap_valid", {31'd0, InstrValid}, 32'd0);
    Redirect = 1'b0;
    tick();
    check_value("wrap_ipc",  InstrPC,     32'hFFFF_FFFC);
    check_value("wrap_pc4",  PCPlus4,     32'h0000_0000);
    check_value("wrap_ins",  Instruction, 32'h0FFF_FFFC);
    check_value("wrap_next", IMemAddr,    32'h0000_0000);
    tick();
    check_value("addr_after_wrap", IMemAddr, 32'h0000_0004);

    // Reset in the middle of DISCARD
    IMemReady = 1'b0; Redirect = 1'b1; RedirectPC = 32'h0000_0200;
    tick();
    check_value("pre_rst_addr", IMemAddr, 32'h0000_0004);
    Redirect = 1'b0; Reset = 1'b1; IMemReady = 1'b1;
    tick();
    check_value("mid_rst_req",  {31'd0, IMemReq}, 32'd0);
    check_value("mid_rst_addr", IMemAddr,         32'h0000_0000);
    check_value("mid_rst_ipc",  InstrPC,          32'h0000_0000);
    Reset = 1'b0;
    tick();
    check_value("post_rst_req",  {31'd0, IMemReq}, 32'd1);
    check_value("post_rst_addr", IMemAddr,         32'h0000_0000);
    tick();
    check_value("post_rst_ins",  Instruction, 32'h1000_0000);
    check_value("post_rst_addr2", IMemAddr,   32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
